uart_trx: RTL and testbench

- Full-duplex 8N1 UART transceiver: one independent transmitter path and one independent receiver path, sharing a clock.
- Sits between a byte-wide on-chip interface and the serial tx/rx pins.
- Bit timing comes from a fixed clocks-per-bit divisor. The default of 142 gives about 115200 baud from a 16.368 MHz clock.

---
 rtl/uart_trx_pkg.sv | 17 +
 rtl/uart_trx_rx.sv | 110 +++++++++++
 rtl/uart_trx.sv | 136 +++++++++++++
 tb/tb_uart_trx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_trx_pkg.sv
// Shared definitions for the uart_trx transceiver: frame geometry, default
// bit divisor and the state encoding used by both the TX and RX FSMs.
package uart_trx_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 142;
  localparam int IDX_W            = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } uart_state_e;

endpackage

// File: rtl/uart_trx_rx.sv
// 8N1 receiver: 2-flop input synchronizer, mid-bit sampling FSM and the
// holding/output registers. A framing error silently drops the byte.
module uart_trx_rx
  import uart_trx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_in_n,
  input  logic                 rx_in,
  output logic                 rx_dv_out,
  output logic [DATA_BITS-1:0] rx_data_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rx_s;
  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 dv_q, dv_d;

  // Synchronizer resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) sync_q <= 2'b11;
    else           sync_q <= {sync_q[0], rx_in};
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_MAX) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = CLEANUP;
          if (rx_s) begin
            data_d = shift_q;
            dv_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLEANUP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rx_dv_out   = dv_q;
  assign rx_data_out = data_q;

endmodule

// File: rtl/uart_trx.sv
// Full-duplex 8N1 UART: inline transmitter plus uart_trx_rx receiver.
// Define UART_LOOPBACK_EN to feed the receiver from tx_out instead of rx_in.
module uart_trx
  import uart_trx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_in_n,
  input  logic                 tx_dv_in,
  input  logic [DATA_BITS-1:0] tx_data_in,
  output logic                 tx_active_out,
  output logic                 tx_out,
  output logic                 tx_done_out,
  input  logic                 rx_in,
  output logic                 rx_dv_out,
  output logic [DATA_BITS-1:0] rx_data_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_BITS - 1);

  uart_state_e          tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_byte_q, tx_byte_d;
  logic                 tx_q, tx_d;
  logic                 tx_act_q, tx_act_d;
  logic                 tx_done_q, tx_done_d;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_byte_q  <= '0;
      tx_q       <= 1'b1;
      tx_act_q   <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_byte_q  <= tx_byte_d;
      tx_q       <= tx_d;
      tx_act_q   <= tx_act_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // The line level is registered one bit ahead, so each state's outgoing
  // edge also loads the value of the bit that follows it.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_byte_d  = tx_byte_q;
    tx_d       = tx_q;
    tx_act_d   = tx_act_q;
    tx_done_d  = 1'b0;
    unique case (tx_state_q)
      IDLE: begin
        tx_d     = 1'b1;
        tx_cnt_d = '0;
        tx_idx_d = '0;
        if (tx_dv_in) begin
          tx_byte_d  = tx_data_in;
          tx_d       = 1'b0;
          tx_act_d   = 1'b1;
          tx_state_d = START;
        end
      end
      START: begin
        if (tx_cnt_q == CNT_MAX) begin
          tx_cnt_d   = '0;
          tx_d       = tx_byte_q[0];
          tx_state_d = DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (tx_cnt_q == CNT_MAX) begin
          tx_cnt_d = '0;
          if (tx_idx_q == IDX_MAX) begin
            tx_idx_d   = '0;
            tx_d       = 1'b1;
            tx_state_d = STOP;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
            tx_d     = tx_byte_q[tx_idx_q + 1'b1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (tx_cnt_q == CNT_MAX) begin
          tx_cnt_d   = '0;
          tx_done_d  = 1'b1;
          tx_act_d   = 1'b0;
          tx_state_d = CLEANUP;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      CLEANUP: tx_state_d = IDLE;
      default: tx_state_d = IDLE;
    endcase
  end

  assign tx_out        = tx_q;
  assign tx_active_out = tx_act_q;
  assign tx_done_out   = tx_done_q;

  logic rx_src;
`ifdef UART_LOOPBACK_EN
  logic unused_rx_in;
  assign unused_rx_in = rx_in;
  assign rx_src       = tx_q;
`else
  assign rx_src = rx_in;
`endif

  uart_trx_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_in     (clk_in),
    .rst_in_n   (rst_in_n),
    .rx_in      (rx_src),
    .rx_dv_out  (rx_dv_out),
    .rx_data_out(rx_data_out)
  );

endmodule

// File: tb/tb_uart_trx.sv
// Directed bench for uart_trx: TX framing/timing, external loopback of the
// receiver, glitch and framing-error rejection, overlap and mid-frame reset.
module tb_uart_trx;

  localparam int C = 142;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_dv;
  logic [7:0] tx_data;
  logic       tx_active, tx_out, tx_done;
  logic       rx_dv;
  logic [7:0] rx_data;
  logic       loop_sel;
  logic       rx_drv;
  logic       rx_pin;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] last_rx;

  assign rx_pin = loop_sel ? tx_out : rx_drv;

  always #5 clk = ~clk;

  uart_trx #(.CLKS_PER_BIT(C)) dut (
    .clk_in       (clk),
    .rst_in_n     (rst_n),
    .tx_dv_in     (tx_dv),
    .tx_data_in   (tx_data),
    .tx_active_out(tx_active),
    .tx_out       (tx_out),
    .tx_done_out  (tx_done),
    .rx_in        (rx_pin),
    .rx_dv_out    (rx_dv),
    .rx_data_out  (rx_data)
  );

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one request, then observes 10*C+11 cycles. Cycle i is the i-th
  // negedge after the edge that samples the request.
  task automatic run_frame(input logic [7:0] b, input int inj_at, input logic [7:0] inj_b,
                           output logic [9:0] bits, output int done_at, output int act_cyc,
                           output int dv_cnt, output logic [7:0] dv_data);
    bits = '0; done_at = -1; act_cyc = 0; dv_cnt = 0; dv_data = '0;
    @(negedge clk);
    tx_dv = 1'b1; tx_data = b;
    for (int i = 0; i <= 10*C + 10; i++) begin
      @(negedge clk);
      tx_dv   = (i == inj_at);
      tx_data = (i == inj_at) ? inj_b : 8'h00;
      if ((i % C) == C/2 && (i / C) < 10) bits[i / C] = tx_out;
      if (tx_active) act_cyc++;
      if (tx_done && done_at < 0) done_at = i;
      if (rx_dv) begin dv_cnt++; dv_data = rx_data; end
    end
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop_bit,
                          output int dv_cnt, output logic [7:0] dv_data);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    dv_cnt = 0; dv_data = '0;
    for (int k = 0; k < 10; k++) begin
      rx_drv = fr[k];
      repeat (C) begin
        @(negedge clk);
        if (rx_dv) begin dv_cnt++; dv_data = rx_data; end
      end
    end
    rx_drv = 1'b1;
    repeat (3*C) begin
      @(negedge clk);
      if (rx_dv) begin dv_cnt++; dv_data = rx_data; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; tx_dv = 1'b0; tx_data = '0; rx_drv = 1'b1; loop_sel = 1'b1;
    repeat (3) @(negedge clk);
    if (tx_out !== 1'b1)    begin n_err++; $display("FAIL rst_tx_out: got %b want 1", tx_out); end
    if (tx_active !== 1'b0) begin n_err++; $display("FAIL rst_tx_active: got %b want 0", tx_active); end
    if (tx_done !== 1'b0)   begin n_err++; $display("FAIL rst_tx_done: got %b want 0", tx_done); end
    if (rx_dv !== 1'b0)     begin n_err++; $display("FAIL rst_rx_dv: got %b want 0", rx_dv); end
    if (rx_data !== 8'h00)  begin n_err++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
    n_cmp += 5;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    if (tx_out !== 1'b1 || tx_active !== 1'b0) begin
      n_err++; $display("FAIL idle_after_rst: tx_out %b active %b want 1 0", tx_out, tx_active);
    end
    n_cmp++;
    last_rx = 8'h00;
  endtask

  task automatic test_loopback_a5;
    logic [9:0] bits; int done_at, act, dvc; logic [7:0] dvd;
    loop_sel = 1'b1;
    run_frame(8'hA5, -1, 8'h00, bits, done_at, act, dvc, dvd);
    if (bits !== 10'b1_1010_0101_0) begin n_err++; $display("FAIL a5_bits: got %b want 1101001010", bits); end
    if (done_at != 10*C) begin n_err++; $display("FAIL a5_done_at: got %0d want %0d", done_at, 10*C); end
    if (act != 10*C)     begin n_err++; $display("FAIL a5_active: got %0d want %0d", act, 10*C); end
    if (dvc != 1)        begin n_err++; $display("FAIL a5_dv_cnt: got %0d want 1", dvc); end
    if (dvd !== 8'hA5)   begin n_err++; $display("FAIL a5_dv_data: got %h want a5", dvd); end
    if (rx_data !== 8'hA5) begin n_err++; $display("FAIL a5_rx_hold: got %h want a5", rx_data); end
    n_cmp += 6;
    last_rx = 8'hA5;
  endtask

  task automatic test_edge_values;
    logic [7:0] vals [4];
    logic [9:0] bits; int done_at, act, dvc; logic [7:0] dvd;
    vals = '{8'h00, 8'hFF, 8'h01, 8'h80};
    loop_sel = 1'b1;
    foreach (vals[j]) begin
      run_frame(vals[j], -1, 8'h00, bits, done_at, act, dvc, dvd);
      if (bits !== {1'b1, vals[j], 1'b0}) begin
        n_err++; $display("FAIL edge_bits_%h: got %b want %b", vals[j], bits, {1'b1, vals[j], 1'b0});
      end
      if (act != 10*C) begin n_err++; $display("FAIL edge_active_%h: got %0d want %0d", vals[j], act, 10*C); end
      if (dvc != 1 || dvd !== vals[j]) begin
        n_err++; $display("FAIL edge_rx_%h: got cnt %0d data %h want 1 %h", vals[j], dvc, dvd, vals[j]);
      end
      n_cmp += 3;
      last_rx = vals[j];
    end
  endtask

  task automatic test_random;
    logic [9:0] bits; int done_at, act, dvc; logic [7:0] dvd, b;
    loop_sel = 1'b1;
    for (int n = 0; n < 32; n++) begin
      b = 8'($urandom_range(0, 255));
      run_frame(b, -1, 8'h00, bits, done_at, act, dvc, dvd);
      if (dvc != 1 || dvd !== b) begin
        n_err++; $display("FAIL rand_%0d: got cnt %0d data %h want 1 %h", n, dvc, dvd, b);
      end
      n_cmp++;
      last_rx = b;
    end
  endtask

  task automatic test_glitch;
    int dvc;
    loop_sel = 1'b0; rx_drv = 1'b1;
    dvc = 0;
    repeat (5) @(negedge clk);
    rx_drv = 1'b0;
    repeat (20) @(negedge clk) if (rx_dv) dvc++;
    rx_drv = 1'b1;
    repeat (3*C) @(negedge clk) if (rx_dv) dvc++;
    if (dvc != 0) begin n_err++; $display("FAIL glitch_dv: got %0d pulses want 0", dvc); end
    if (rx_data !== last_rx) begin n_err++; $display("FAIL glitch_hold: got %h want %h", rx_data, last_rx); end
    n_cmp += 2;
  endtask

  task automatic test_framing;
    int dvc; logic [7:0] dvd;
    loop_sel = 1'b0;
    drive_rx(8'h3C, 1'b0, dvc, dvd);
    if (dvc != 0) begin n_err++; $display("FAIL frame_err_dv: got %0d pulses want 0", dvc); end
    if (rx_data !== last_rx) begin n_err++; $display("FAIL frame_err_hold: got %h want %h", rx_data, last_rx); end
    drive_rx(8'h5A, 1'b1, dvc, dvd);
    if (dvc != 1 || dvd !== 8'h5A) begin
      n_err++; $display("FAIL frame_ok: got cnt %0d data %h want 1 5a", dvc, dvd);
    end
    n_cmp += 3;
    last_rx = 8'h5A;
  endtask

  task automatic test_overlap;
    logic [9:0] bits; int done_at, act, dvc; logic [7:0] dvd;
    loop_sel = 1'b1;
    run_frame(8'h22, 100, 8'h11, bits, done_at, act, dvc, dvd);
    if (bits !== {1'b1, 8'h22, 1'b0}) begin n_err++; $display("FAIL ovl_bits: got %b want %b", bits, {1'b1, 8'h22, 1'b0}); end
    if (dvc != 1 || dvd !== 8'h22) begin n_err++; $display("FAIL ovl_rx: got cnt %0d data %h want 1 22", dvc, dvd); end
    if (tx_active !== 1'b0 || tx_out !== 1'b1) begin
      n_err++; $display("FAIL ovl_idle: active %b tx_out %b want 0 1", tx_active, tx_out);
    end
    n_cmp += 3;
    last_rx = 8'h22;
  endtask

  task automatic test_mid_reset;
    logic [9:0] bits; int done_at, act, dvc; logic [7:0] dvd;
    int bad;
    loop_sel = 1'b1;
    @(negedge clk); tx_dv = 1'b1; tx_data = 8'hC3;
    @(negedge clk); tx_dv = 1'b0;
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    #1;
    if (tx_out !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0 || rx_dv !== 1'b0) begin
      n_err++; $display("FAIL midrst_abort: tx_out %b active %b done %b dv %b want 1 0 0 0", tx_out, tx_active, tx_done, rx_dv);
    end
    if (rx_data !== 8'h00) begin n_err++; $display("FAIL midrst_rx_data: got %h want 00", rx_data); end
    n_cmp += 2;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (12*C) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || tx_active || tx_done || rx_dv) bad++;
    end
    if (bad != 0) begin n_err++; $display("FAIL midrst_quiet: got %0d busy cycles want 0", bad); end
    n_cmp++;
    run_frame(8'h6B, -1, 8'h00, bits, done_at, act, dvc, dvd);
    if (bits !== {1'b1, 8'h6B, 1'b0}) begin n_err++; $display("FAIL midrst_bits: got %b want %b", bits, {1'b1, 8'h6B, 1'b0}); end
    if (dvc != 1 || dvd !== 8'h6B) begin n_err++; $display("FAIL midrst_rx: got cnt %0d data %h want 1 6b", dvc, dvd); end
    if (done_at != 10*C) begin n_err++; $display("FAIL midrst_done_at: got %0d want %0d", done_at, 10*C); end
    n_cmp += 3;
  endtask

  initial begin
    test_reset();
    test_loopback_a5();
    test_edge_values();
    test_random();
    test_glitch();
    test_framing();
    test_overlap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
